// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared types and defaults for the contador run sequencer
package contador_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        GAP,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] DEF_LIMIT = '1;
    localparam int               DEF_REPS  = 1;
    localparam int               DEF_GAP   = 0;

endpackage

// File: rtl/contador_gap_timer.sv
// rtl/contador_gap_timer.sv - loadable down-counter timing the idle gap between runs
module contador_gap_timer #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [GAP_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - GAP_W'(1);
        end
    end

    // A zero-length gap still occupies one cycle, so 0 and 1 both mean "last".
    assign last = (count <= GAP_W'(1));

endmodule

// File: rtl/contador_seq_ctrl.sv
// rtl/contador_seq_ctrl.sv - run sequencer driving enable/clear of the contador counter
module contador_seq_ctrl #(
    parameter int CNT_W = contador_pkg::CNT_W,
    parameter int REP_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic             cfg_cont,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] run_count
);

    import contador_pkg::*;

    state_t           state;
    logic [CNT_W-1:0] limit_q;
    logic [REP_W-1:0] reps_q;
    logic [GAP_W-1:0] gap_q;
    logic             cont_q;
    logic             at_limit;
    logic             gap_load;
    logic             gap_last;

    assign at_limit = (cnt_val == limit_q);
    assign gap_load = (state == RUN) && !stop && at_limit;

    contador_gap_timer #(
        .GAP_W(GAP_W)
    ) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (gap_load),
        .load_val(gap_q),
        .en      (state == GAP),
        .last    (gap_last)
    );

    // Enable is combinational so the counter stops on the very cycle it reaches the limit.
    assign cnt_en  = (state == RUN) && !at_limit && !stop;
    assign cnt_clr = (state == ARM) || ((state == GAP) && gap_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            run_count <= '0;
            limit_q   <= CNT_W'(DEF_LIMIT);
            reps_q    <= REP_W'(DEF_REPS);
            gap_q     <= GAP_W'(DEF_GAP);
            cont_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        limit_q <= cfg_limit;
                        reps_q  <= cfg_reps;
                        gap_q   <= cfg_gap;
                        cont_q  <= cfg_cont;
                    end
                    if (start) begin
                        state     <= ARM;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        run_count <= '0;
                    end
                end
                ARM: begin
                    if (stop || (!cont_q && (reps_q == '0))) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (at_limit) begin
                        if (run_count != '1) begin
                            run_count <= run_count + REP_W'(1);
                        end
                        if (!cont_q && ((run_count + REP_W'(1)) == reps_q)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (gap_last) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
